// File: rtl/ex_mem_stage_if.sv
// Execute-to-memory stage bundle: upstream handshake, downstream handshake and status flags.
// Ports: flush, in_* (ALU result, flags, store data, dest, control), out_* (head entry), status_nzcv.
// master = surrounding pipeline (drives in_*, out_ready, flush); slave = the stage itself.
interface ex_mem_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic              in_zero;
  logic              in_overflow;
  logic              in_carryout;
  logic              in_negative;
  logic [DATA_W-1:0] in_store_data;
  logic [REG_W-1:0]  in_rd;
  logic              in_reg_write;
  logic              in_mem_read;
  logic              in_mem_write;
  logic              in_set_flags;
  logic              in_trap_ovf;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [DATA_W-1:0] out_store_data;
  logic [REG_W-1:0]  out_rd;
  logic              out_reg_write;
  logic              out_mem_read;
  logic              out_mem_write;
  logic              out_exc;
  logic [3:0]        status_nzcv;

  modport master (
    output flush, in_valid, in_result, in_zero, in_overflow, in_carryout, in_negative,
           in_store_data, in_rd, in_reg_write, in_mem_read, in_mem_write, in_set_flags,
           in_trap_ovf, out_ready,
    input  in_ready, out_valid, out_result, out_store_data, out_rd, out_reg_write,
           out_mem_read, out_mem_write, out_exc, status_nzcv
  );

  modport slave (
    input  flush, in_valid, in_result, in_zero, in_overflow, in_carryout, in_negative,
           in_store_data, in_rd, in_reg_write, in_mem_read, in_mem_write, in_set_flags,
           in_trap_ovf, out_ready,
    output in_ready, out_valid, out_result, out_store_data, out_rd, out_reg_write,
           out_mem_read, out_mem_write, out_exc, status_nzcv
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with 2-entry skid buffer, NZCV status register and overflow trap.
// Latency 1 cycle (push in t -> out_valid in t+1); full throughput with out_ready=1.
// Backpressure: skid absorbs one entry after out_ready drops; in_ready is registered.
// Ports: clk, rst_n (async active-low), bus (ex_mem_stage_if.slave: flush, in_*, out_*, status_nzcv).
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  ex_mem_stage_if.slave      bus
);

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              exc;
  } entry_t;

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_e;

  state_e     state_q, state_d;
  entry_t     head_q, skid_q, in_ent;
  logic       in_ready_q;
  logic [3:0] status_q;
  logic       push, pop, trap;
  logic       head_ld_new, skid_ld, skid_to_head;

  assign push = bus.in_valid & in_ready_q;
  assign pop  = (state_q != ST_EMPTY) & bus.out_ready;
  assign trap = bus.in_trap_ovf & bus.in_overflow;

  // Trapped entries are neutralised at capture so nothing downstream can commit them;
  // result is kept so the trap handler can see what the ALU produced.
  always_comb begin
    in_ent            = '0;
    in_ent.result     = bus.in_result;
    in_ent.store_data = bus.in_store_data;
    in_ent.rd         = bus.in_rd;
    in_ent.reg_write  = bus.in_reg_write & ~trap;
    in_ent.mem_read   = bus.in_mem_read & ~trap;
    in_ent.mem_write  = bus.in_mem_write & ~trap;
    in_ent.exc        = trap;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  // Next-state logic; flush wins over any push/pop in the same cycle
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (push) state_d = ST_ONE;
        ST_ONE: begin
          if (push && !pop)      state_d = ST_FULL;
          else if (!push && pop) state_d = ST_EMPTY;
        end
        ST_FULL:  if (pop) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Output / datapath-control logic
  always_comb begin
    head_ld_new  = 1'b0;
    skid_ld      = 1'b0;
    skid_to_head = 1'b0;
    if (!bus.flush) begin
      case (state_q)
        ST_EMPTY: head_ld_new = push;
        ST_ONE: begin
          head_ld_new = push & pop;
          skid_ld     = push & ~pop;
        end
        ST_FULL:  skid_to_head = pop;
        default: ;
      endcase
    end
  end

  // Entry storage: head only changes on a load, so outputs hold while empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (head_ld_new)       head_q <= in_ent;
      else if (skid_to_head) head_q <= skid_q;
      if (skid_ld)           skid_q <= in_ent;
    end
  end

  // Architectural flags update at push time; trapped and flushed pushes leave them alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= 4'b0000;
    end else if (push && !bus.flush && bus.in_set_flags && !trap) begin
      status_q <= {bus.in_negative, bus.in_zero, bus.in_carryout, bus.in_overflow};
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = (state_q != ST_EMPTY);
  assign bus.out_result     = head_q.result;
  assign bus.out_store_data = head_q.store_data;
  assign bus.out_rd         = head_q.rd;
  assign bus.out_reg_write  = head_q.reg_write;
  assign bus.out_mem_read   = head_q.mem_read;
  assign bus.out_mem_write  = head_q.mem_write;
  assign bus.out_exc        = head_q.exc;
  assign bus.status_nzcv    = status_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: reset, vector table, hand sequences, random vs queue model.
// Inputs change 1ns after the rising edge; outputs (all registered) are sampled there too.
// Reference model: a bounded queue (capacity 2) plus a flags variable.
module tb_ex_mem_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_mem_stage_if #(.DATA_W(32), .REG_W(5)) bus ();
  ex_mem_stage #(.DATA_W(32), .REG_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        rw, mr, mw, exc;
  } ent_t;

  ent_t       mq[$];
  logic [3:0] m_nzcv = 4'b0000;
  int         errs = 0;
  int         checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input bit ordy, input bit fl, input logic [31:0] res,
                       input logic [4:0] rd, input logic [3:0] f, input bit trap,
                       input bit rw, input bit mr, input bit mw, input bit sf);
    bus.in_valid      = v;
    bus.out_ready     = ordy;
    bus.flush         = fl;
    bus.in_result     = res;
    bus.in_store_data = res ^ 32'h5A5A5A5A;
    bus.in_rd         = rd;
    bus.in_negative   = f[3];
    bus.in_zero       = f[2];
    bus.in_carryout   = f[1];
    bus.in_overflow   = f[0];
    bus.in_trap_ovf   = trap;
    bus.in_reg_write  = rw;
    bus.in_mem_read   = mr;
    bus.in_mem_write  = mw;
    bus.in_set_flags  = sf;
  endtask

  // One clock: advance the model by the rules of the handshake, then compare.
  task automatic cycle();
    bit   push, pop, tr;
    ent_t e;
    push  = bus.in_valid && (mq.size() < 2);
    pop   = (mq.size() > 0) && bus.out_ready;
    tr    = bus.in_trap_ovf && bus.in_overflow;
    e.res = bus.in_result;
    e.sd  = bus.in_store_data;
    e.rd  = bus.in_rd;
    e.exc = tr;
    e.rw  = bus.in_reg_write && !tr;
    e.mr  = bus.in_mem_read && !tr;
    e.mw  = bus.in_mem_write && !tr;
    @(posedge clk);
    if (bus.flush) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(e);
        if (bus.in_set_flags && !tr)
          m_nzcv = {bus.in_negative, bus.in_zero, bus.in_carryout, bus.in_overflow};
      end
    end
    #1;
    chk("in_ready", 64'(bus.in_ready), 64'(mq.size() < 2));
    chk("out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
    chk("status_nzcv", 64'(bus.status_nzcv), 64'(m_nzcv));
    if (mq.size() > 0) begin
      chk("out_result", 64'(bus.out_result), 64'(mq[0].res));
      chk("out_store_data", 64'(bus.out_store_data), 64'(mq[0].sd));
      chk("out_rd", 64'(bus.out_rd), 64'(mq[0].rd));
      chk("out_ctrl", 64'({bus.out_reg_write, bus.out_mem_read, bus.out_mem_write, bus.out_exc}),
          64'({mq[0].rw, mq[0].mr, mq[0].mw, mq[0].exc}));
    end
  endtask

  typedef struct {
    bit          v, ordy, fl;
    logic [31:0] res;
    logic [4:0]  rd;
    logic [3:0]  f;
    bit          trap, rw, sf;
    bit          e_ov, e_ir;
    logic [31:0] e_res;
    logic [4:0]  e_rd;
    bit          e_exc, e_rw;
    logic [3:0]  e_nzcv;
  } vec_t;

  vec_t tbl[6];

  initial begin
    // v ordy fl res rd f(NZCV) trap rw sf | out_valid in_ready result rd exc rw nzcv
    tbl[0] = '{1, 1, 0, 32'h02020202, 5'd5, 4'b0000, 0, 1, 0, 1, 1, 32'h02020202, 5'd5, 0, 1, 4'b0000};
    tbl[1] = '{1, 1, 0, 32'hFFFFFFFE, 5'd7, 4'b1001, 1, 1, 1, 1, 1, 32'hFFFFFFFE, 5'd7, 1, 0, 4'b0000};
    tbl[2] = '{1, 1, 0, 32'hFFFFFFFE, 5'd7, 4'b1001, 0, 1, 1, 1, 1, 32'hFFFFFFFE, 5'd7, 0, 1, 4'b1001};
    tbl[3] = '{1, 1, 0, 32'h00000000, 5'd3, 4'b0100, 0, 1, 1, 1, 1, 32'h00000000, 5'd3, 0, 1, 4'b0100};
    tbl[4] = '{1, 1, 0, 32'h80000000, 5'd4, 4'b1000, 0, 0, 0, 1, 1, 32'h80000000, 5'd4, 0, 0, 4'b0100};
    tbl[5] = '{0, 1, 0, 32'h00000000, 5'd0, 4'b0000, 0, 0, 0, 0, 1, 32'h80000000, 5'd4, 0, 0, 4'b0100};

    // Reset held with in_valid asserted
    drive(1, 1, 0, 32'hDEADBEEF, 5'd9, 4'b1111, 0, 1, 1, 1, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst nzcv", 64'(bus.status_nzcv), 64'd0);
    chk("rst out_result", 64'(bus.out_result), 64'd0);
    chk("rst out_ctrl", 64'({bus.out_reg_write, bus.out_mem_read, bus.out_mem_write, bus.out_exc}), 64'd0);
    rst_n = 1'b1;
    drive(0, 1, 0, 32'h0, 5'd0, 4'b0000, 0, 0, 0, 0, 0);
    cycle();

    // Vector table
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].v, tbl[i].ordy, tbl[i].fl, tbl[i].res, tbl[i].rd, tbl[i].f,
            tbl[i].trap, tbl[i].rw, 0, 0, tbl[i].sf);
      cycle();
      chk($sformatf("vec%0d out_valid", i), 64'(bus.out_valid), 64'(tbl[i].e_ov));
      chk($sformatf("vec%0d in_ready", i), 64'(bus.in_ready), 64'(tbl[i].e_ir));
      chk($sformatf("vec%0d result", i), 64'(bus.out_result), 64'(tbl[i].e_res));
      chk($sformatf("vec%0d rd", i), 64'(bus.out_rd), 64'(tbl[i].e_rd));
      chk($sformatf("vec%0d exc", i), 64'(bus.out_exc), 64'(tbl[i].e_exc));
      chk($sformatf("vec%0d reg_write", i), 64'(bus.out_reg_write), 64'(tbl[i].e_rw));
      chk($sformatf("vec%0d nzcv", i), 64'(bus.status_nzcv), 64'(tbl[i].e_nzcv));
    end

    // Streaming: 8 back-to-back pushes, each visible the following cycle
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 0, 32'h1000 + 32'(i), 5'(i), 4'b0000, 0, 1, i[0], ~i[0], 0);
      cycle();
      chk("stream in_ready", 64'(bus.in_ready), 64'd1);
      chk("stream result", 64'(bus.out_result), 64'h1000 + 64'(i));
    end
    drive(0, 1, 0, 32'h0, 5'd0, 4'b0000, 0, 0, 0, 0, 0);
    cycle();

    // Backpressure: A, B absorbed, C held until in_ready returns
    drive(1, 1, 0, 32'hAAAA0001, 5'd1, 4'b0000, 0, 1, 0, 0, 0);
    cycle();
    drive(1, 0, 0, 32'hBBBB0002, 5'd2, 4'b0000, 0, 1, 0, 0, 0);
    cycle();
    chk("bp in_ready low", 64'(bus.in_ready), 64'd0);
    chk("bp head A", 64'(bus.out_result), 64'hAAAA0001);
    drive(1, 0, 0, 32'hCCCC0003, 5'd3, 4'b0000, 0, 1, 0, 0, 0);
    repeat (2) begin
      cycle();
      chk("bp hold A", 64'(bus.out_result), 64'hAAAA0001);
    end
    bus.out_ready = 1'b1;
    cycle();
    chk("bp head B", 64'(bus.out_result), 64'hBBBB0002);
    chk("bp in_ready back", 64'(bus.in_ready), 64'd1);
    cycle();
    chk("bp head C", 64'(bus.out_result), 64'hCCCC0003);
    bus.in_valid = 1'b0;
    cycle();
    chk("bp drained", 64'(bus.out_valid), 64'd0);

    // Flush from FULL with a simultaneous flag-setting push
    drive(1, 0, 0, 32'h11110000, 5'd1, 4'b0000, 0, 1, 0, 0, 0);
    cycle();
    drive(1, 0, 0, 32'h22220000, 5'd2, 4'b0000, 0, 1, 0, 0, 0);
    cycle();
    drive(1, 0, 1, 32'h33330000, 5'd3, 4'b0010, 0, 1, 0, 0, 1);
    cycle();
    chk("flush full out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush full in_ready", 64'(bus.in_ready), 64'd1);
    chk("flush full nzcv", 64'(bus.status_nzcv), 64'b0100);
    // Flush from ONE, where the simultaneous push would otherwise be accepted
    drive(1, 0, 0, 32'h44440000, 5'd4, 4'b0000, 0, 1, 0, 0, 0);
    cycle();
    drive(1, 1, 1, 32'h55550000, 5'd5, 4'b0010, 0, 1, 0, 0, 1);
    cycle();
    chk("flush one nzcv", 64'(bus.status_nzcv), 64'b0100);
    drive(0, 1, 0, 32'h0, 5'd0, 4'b0000, 0, 0, 0, 0, 0);
    repeat (2) begin
      cycle();
      chk("flush never popped", 64'(bus.out_valid), 64'd0);
    end

    // Random traffic against the queue model
    for (int i = 0; i < 600; i++) begin
      if (!(bus.in_valid && mq.size() >= 2)) begin
        drive($urandom_range(0, 3) != 0, 1, 0, $urandom, 5'($urandom),
              4'($urandom), $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
              $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
      end
      bus.out_ready = $urandom_range(0, 2) != 0;
      bus.flush     = $urandom_range(0, 24) == 0;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
